// File: rtl/key_schedule_seq.sv
// Iterative AES key expansion, one word per cycle, sharing one external SubWord unit; keys_ready 4*(nr+1)-nk cycles after start.
// Round-key reads return 1 cycle later with a one-cycle rk_valid; there is no backpressure, and reads that cannot be served are dropped.
module key_schedule_seq #(
   parameter int nk = 4,
   parameter int nr = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [32*nk-1:0] key_in,
   output logic             busy,
   output logic             keys_ready,
   output logic [31:0]      sub_word_out,
   input  logic [31:0]      sub_word_in,
   input  logic             rk_rd,
   input  logic [3:0]       rk_idx,
   output logic [127:0]     rk_out,
   output logic             rk_valid
);

   localparam int         nw     = 4 * (nr + 1);
   localparam logic [5:0] nk_w   = 6'(nk);
   localparam logic [5:0] last_w = 6'(nw - 1);
   localparam logic [2:0] j_last = 3'(nk - 1);
   localparam logic [3:0] nr_w   = 4'(nr);

   typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

   state_t      state;
   logic [31:0] w [nw];
   logic [5:0]  i;
   logic [2:0]  j;
   logic [7:0]  rcon;
   logic [31:0] prev;
   logic [31:0] temp;
   logic [5:0]  base;
   logic        rd_ok;

   assign prev  = w[i - 6'd1];
   assign base  = {rk_idx, 2'b00};
   // A start in DONE wins over a read issued in the same cycle.
   assign rd_ok = keys_ready && rk_rd && (rk_idx <= nr_w) && !start;

   always_comb begin
      sub_word_out = 32'h0;
      temp         = prev;
      if (state == EXPAND) begin
         sub_word_out = prev;
         if (j == 3'd0) begin
            sub_word_out = {prev[23:0], prev[31:24]};
            temp         = sub_word_in ^ {rcon, 24'h0};
         end else if (nk > 6 && j == 3'd4) begin
            temp = sub_word_in;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         busy       <= 1'b0;
         keys_ready <= 1'b0;
         rk_valid   <= 1'b0;
         rk_out     <= 128'h0;
         rcon       <= 8'h01;
         i          <= 6'd0;
         j          <= 3'd0;
      end else begin
         rk_valid <= 1'b0;
         if (rd_ok) begin
            rk_valid <= 1'b1;
            rk_out   <= {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]};
         end
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  for (int k = 0; k < nk; k++)
                     w[k] <= key_in[32*(nk-k)-1 -: 32];
                  i          <= nk_w;
                  j          <= 3'd0;
                  rcon       <= 8'h01;
                  state      <= EXPAND;
                  busy       <= 1'b1;
                  keys_ready <= 1'b0;
               end
            end
            EXPAND: begin
               w[i] <= w[i - nk_w] ^ temp;
               i    <= i + 6'd1;
               j    <= (j == j_last) ? 3'd0 : j + 3'd1;
               if (j == 3'd0)
                  rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
               if (i == last_w) begin
                  state      <= DONE;
                  busy       <= 1'b0;
                  keys_ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
